// File: rtl/pipelined_adder_acc.sv
// Purpose : single-stage add/sub/accumulate unit with a valid/ready handshake on both sides.
// Latency : one cycle from accept to out_valid; a new operation can be accepted every cycle.
// Backpres: while out_valid && !out_ready the result register holds and in_ready stays low.
//
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid / in_ready  - operation handshake (op, A, B sampled only on accept)
//   op                   - 00 ADD, 01 SUB, 10 ACC, 11 CLR
//   A, B                 - unsigned operands (B unused by ACC and CLR)
//   out_valid/out_ready  - result handshake
//   SUM                  - registered WIDTH+1 bit result (carry/borrow in the top bit)
//   acc_ovf              - sticky flag: the accumulator has wrapped since the last CLR/reset
//   txn_count            - free-running count of consumed results
module pipelined_adder_acc #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   SUM,
  output logic             acc_ovf,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [WIDTH:0]   acc;
  logic             accept;
  logic             consume;

  // Next-state values computed from the operands presented this cycle;
  // they only land in the registers when accept is high.
  logic [WIDTH:0]   res_next;
  logic [WIDTH:0]   acc_next;
  logic             ovf_next;
  logic [WIDTH+1:0] acc_wide;

  // The output slot is free when empty or being drained this edge, which is
  // what allows one accept per cycle with out_ready held high.
  assign in_ready = (!out_valid || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // One extra bit above the accumulator captures the wrap out of bit WIDTH.
  assign acc_wide = {1'b0, acc} + {2'b00, A};

  always_comb begin
    res_next = '0;
    acc_next = acc;
    ovf_next = acc_ovf;
    case (op)
      OP_ADD: begin
        res_next = {1'b0, A} + {1'b0, B};
      end
      OP_SUB: begin
        // Modulo 2^(WIDTH+1): the top bit becomes the borrow when A < B.
        res_next = {1'b0, A} - {1'b0, B};
      end
      OP_ACC: begin
        acc_next = acc_wide[WIDTH:0];
        ovf_next = acc_ovf | acc_wide[WIDTH+1];
        res_next = acc_wide[WIDTH:0];
      end
      OP_CLR: begin
        acc_next = '0;
        ovf_next = 1'b0;
        res_next = '0;
      end
      default: begin
        res_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SUM       <= '0;
      out_valid <= 1'b0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        SUM       <= res_next;
        out_valid <= 1'b1;
        acc       <= acc_next;
        acc_ovf   <= ovf_next;
      end else if (consume) begin
        // SUM keeps its last value; only the valid flag drops.
        out_valid <= 1'b0;
      end
      if (consume) begin
        txn_count <= txn_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_acc.sv
module tb_pipelined_adder_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [3:0] A;
  logic [3:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] SUM;
  logic       acc_ovf;
  logic [7:0] txn_count;

  int nvec = 0;
  int errs = 0;

  pipelined_adder_acc #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (SUM),
    .acc_ovf   (acc_ovf),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    in_valid = v;
    op       = o;
    A        = a;
    B        = b;
  endtask

  initial begin
    logic [4:0] exp_sum;
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b1, 2'b00, 4'd3, 4'd3);
    #1;
    chk("in_ready_in_reset", in_ready, 0);
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", SUM, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
    chk("rst_txn", txn_count, 0);
    rst = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // ADD 9+8 -> 17
    drive(1'b1, 2'b00, 4'd9, 4'd8);
    cyc();
    chk("add9_8_valid", out_valid, 1);
    chk("add9_8_sum", SUM, 17);
    chk("add9_8_txn_pre", txn_count, 0);
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    cyc();
    chk("add9_8_drained", out_valid, 0);
    chk("add9_8_txn", txn_count, 1);

    // Reset so the exhaustive sweep starts counting from zero.
    rst = 1'b1;
    cyc();
    chk("rst2_txn", txn_count, 0);
    rst = 1'b0;

    // Exhaustive back-to-back ADD sweep.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'b00, i[7:4], i[3:0]);
      cyc();
      exp_sum = {1'b0, i[7:4]} + {1'b0, i[3:0]};
      chk("sweep_sum", SUM, exp_sum);
      chk("sweep_valid", out_valid, 1);
    end
    chk("sweep_txn_255", txn_count, 255);
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    cyc();
    chk("sweep_txn_wrap", txn_count, 0);
    chk("sweep_drained", out_valid, 0);

    // SUB with and without borrow, back-to-back.
    drive(1'b1, 2'b01, 4'd3, 4'd5);
    cyc();
    chk("sub3_5", SUM, 30);
    drive(1'b1, 2'b01, 4'd5, 4'd3);
    cyc();
    chk("sub5_3", SUM, 2);
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    cyc();
    chk("sub_txn", txn_count, 2);

    // CLR, ACC 15 x3 (wraps on the third), ADD keeps acc_ovf, CLR clears it.
    drive(1'b1, 2'b11, 4'd7, 4'd7);
    cyc();
    chk("clr1_sum", SUM, 0);
    chk("clr1_valid", out_valid, 1);
    chk("clr1_ovf", acc_ovf, 0);
    drive(1'b1, 2'b10, 4'd15, 4'd9);
    cyc();
    chk("acc1_sum", SUM, 15);
    chk("acc1_ovf", acc_ovf, 0);
    cyc();
    chk("acc2_sum", SUM, 30);
    chk("acc2_ovf", acc_ovf, 0);
    cyc();
    chk("acc3_sum", SUM, 13);
    chk("acc3_ovf", acc_ovf, 1);
    drive(1'b1, 2'b00, 4'd1, 4'd1);
    cyc();
    chk("add_after_acc_sum", SUM, 2);
    chk("add_after_acc_ovf", acc_ovf, 1);
    drive(1'b1, 2'b11, 4'd0, 4'd0);
    cyc();
    chk("clr2_sum", SUM, 0);
    chk("clr2_ovf", acc_ovf, 0);
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    cyc();
    chk("acc_sect_txn", txn_count, 8);

    // Backpressure: ADD 7+7 held for 3 cycles while other operands are offered.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 4'd7, 4'd7);
    cyc();
    chk("bp_first_sum", SUM, 14);
    drive(1'b1, 2'b01, 4'd1, 4'd2);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold_sum", SUM, 14);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_txn", txn_count, 8);
    end
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    cyc();
    chk("bp_consumed_valid", out_valid, 0);
    chk("bp_consumed_txn", txn_count, 9);

    // Back-to-back 1+1, 2+2, 3+3.
    drive(1'b1, 2'b00, 4'd1, 4'd1);
    cyc();
    chk("b2b_1", SUM, 2);
    chk("b2b_1_valid", out_valid, 1);
    drive(1'b1, 2'b00, 4'd2, 4'd2);
    cyc();
    chk("b2b_2", SUM, 4);
    chk("b2b_2_valid", out_valid, 1);
    drive(1'b1, 2'b00, 4'd3, 4'd3);
    cyc();
    chk("b2b_3", SUM, 6);
    chk("b2b_3_valid", out_valid, 1);
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    cyc();
    chk("b2b_txn", txn_count, 12);

    // Pending ACC with acc_ovf set, then reset mid-operation.
    drive(1'b1, 2'b10, 4'd15, 4'd0);
    cyc(); cyc(); cyc();
    chk("pre_rst_sum", SUM, 13);
    chk("pre_rst_ovf", acc_ovf, 1);
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    cyc();
    chk("pre_rst_held", out_valid, 1);
    chk("pre_rst_txn", txn_count, 14);
    rst = 1'b1;
    drive(1'b1, 2'b00, 4'd5, 4'd5);
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    cyc();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", SUM, 0);
    chk("mid_rst_ovf", acc_ovf, 0);
    chk("mid_rst_txn", txn_count, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 4'd4, 4'd0);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    cyc();
    chk("post_rst_acc4", SUM, 4);
    chk("post_rst_valid", out_valid, 1);
    drive(1'b0, 2'b00, 4'd0, 4'd0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_acc.md
PIPELINED_ADDER_ACC -- requirements
Module: pipelined_adder_acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the transaction counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, high when an operation is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, high when the block can accept an operation.
REQ-007 The block SHALL have port op, input, 2 bits, operation code: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-008 The block SHALL have port A, input, WIDTH bits, unsigned operand.
REQ-009 The block SHALL have port B, input, WIDTH bits, unsigned operand; ignored for ACC and CLR.
REQ-010 The block SHALL have port out_valid, output, 1 bit, high while SUM holds an unconsumed result.
REQ-011 The block SHALL have port out_ready, input, 1 bit, high when the consumer takes the result.
REQ-012 The block SHALL have port SUM, output, WIDTH+1 bits, registered result including carry/borrow bit.
REQ-013 The block SHALL have port acc_ovf, output, 1 bit, sticky accumulator wrap flag.
REQ-014 The block SHALL have port txn_count, output, CNT_W bits, count of results consumed.

Function
REQ-015 Accept SHALL occur on a clock edge where in_valid && in_ready; result SHALL appear on SUM with out_valid=1 exactly one cycle after accept.
REQ-016 in_ready SHALL equal (!out_valid || out_ready) && !rst, combinationally; back-to-back accepts every cycle SHALL be possible when out_ready is held high.
REQ-017 While out_valid && !out_ready, SUM and out_valid SHALL hold unchanged and no new operation SHALL be accepted.
REQ-018 out_valid SHALL clear on the edge where out_valid && out_ready unless a new accept occurs on the same edge, in which case it SHALL stay high with the new result.
REQ-019 ADD: SUM SHALL be zero-extended A + zero-extended B, full WIDTH+1-bit result, no truncation.
REQ-020 SUB: SUM SHALL be (A - B) modulo 2^(WIDTH+1); SUM[WIDTH]=1 exactly when A < B.
REQ-021 ACC: internal accumulator (WIDTH+1 bits) SHALL update to (acc + A) modulo 2^(WIDTH+1); SUM SHALL show the new accumulator value.
REQ-022 ACC wrap (carry out of bit WIDTH) SHALL set acc_ovf; acc_ovf SHALL stay set until CLR or reset.
REQ-023 CLR: accumulator, acc_ovf SHALL clear to 0; SUM SHALL be 0 with out_valid=1 one cycle later.
REQ-024 ADD and SUB SHALL NOT modify the accumulator or acc_ovf.
REQ-025 txn_count SHALL increment by 1 on every edge where out_valid && out_ready, wrapping from 2^CNT_W-1 to 0.
REQ-026 Operands and op SHALL be sampled only at accept; changes at other times SHALL have no effect.

Reset
REQ-027 On an edge with rst=1: SUM=0, out_valid=0, accumulator=0, acc_ovf=0, txn_count=0, regardless of other inputs.
REQ-028 Reset mid-operation SHALL discard any pending unconsumed result; in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.

Verification (WIDTH=4, CNT_W=8)
REQ-029 ADD A=9,B=8, out_ready=1 -> next cycle out_valid=1, SUM=5'b10001 (17); then exhaustive sweep of all 256 {A,B} ADD combos -> SUM=A+B each, txn_count=256 wraps to 0.
REQ-030 SUB A=3,B=5 -> SUM=5'b11110 (30); SUB A=5,B=3 -> SUM=2.
REQ-031 CLR, then ACC A=15 three times -> SUM 15, 30, 13; acc_ovf=0,0,1; a further ADD 1+1 -> SUM=2, acc_ovf still 1; CLR -> SUM=0, acc_ovf=0.
REQ-032 ADD 7+7 with out_ready=0 for 3 cycles -> SUM=14 held, out_valid=1, in_ready=0, txn_count unchanged; out_ready=1 -> consumed, txn_count +1.
REQ-033 Back-to-back ADDs 1+1, 2+2, 3+3 on consecutive cycles, out_ready=1 -> SUM 2,4,6 on consecutive cycles, out_valid continuously high.
REQ-034 Pending ACC result with out_ready=0, assert rst one cycle -> out_valid=0, SUM=0, acc_ovf=0, txn_count=0; following ACC A=4 -> SUM=4.
